execute_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline, directly upstream of the memory stage.
- Resolves operand forwarding and computes the ALU result, branch/jump decision and branch target.
- Implements an iterative multi-cycle multiplier (RV32M MUL/MULH/MULHSU/MULHU) that stalls the front of the pipeline while it runs.
- Registers everything the memory stage consumes in the execute/memory pipeline register.

---
 rtl/execute_stage.sv | 179 +++++++++++++++++
 tb/tb_execute_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution, an iterative
// RV32M multiplier that stalls the front end, and the E/M pipeline register.
module execute_stage #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [4:0]  rd_e,
    input  logic [31:0] rd1_e,
    input  logic [31:0] rd2_e,
    input  logic [31:0] imm_ext_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] pc_plus4_e,
    input  logic        reg_write_e,
    input  logic [1:0]  result_src_e,
    input  logic        mem_write_e,
    input  logic        jump_e,
    input  logic        jalr_e,
    input  logic        branch_e,
    input  logic [2:0]  funct3_e,
    input  logic        alu_src_e,
    input  logic [3:0]  alu_control_e,
    input  logic        mul_e,
    input  logic [1:0]  mul_op_e,
    input  logic [1:0]  forward_a_e,
    input  logic [1:0]  forward_b_e,
    input  logic [31:0] result_w,
    output logic [4:0]  rd_m,
    output logic [31:0] alu_result_m,
    output logic [31:0] write_data_m,
    output logic [31:0] pc_plus4_m,
    output logic        reg_write_m,
    output logic [1:0]  result_src_m,
    output logic        mem_write_m,
    output logic        pc_src_e,
    output logic [31:0] pc_target_e,
    output logic        mul_busy_e
);

    localparam int K = MUL_BITS_PER_CYCLE;
    localparam int N = 32 / MUL_BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t  state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [1:0]  op;
    logic        negate;

    logic [31:0] src_a, fwd_b, src_b, alu_result;
    logic        taken;
    logic        a_signed, b_signed, neg_start;
    logic [31:0] a_mag, b_mag, mul_result;
    logic [63:0] partial, product;

    always_comb begin
        case (forward_a_e)
            2'b01:   src_a = result_w;
            2'b10:   src_a = alu_result_m;
            default: src_a = rd1_e;
        endcase
        case (forward_b_e)
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = alu_result_m;
            default: fwd_b = rd2_e;
        endcase
        src_b = alu_src_e ? imm_ext_e : fwd_b;
    end

    always_comb begin
        case (alu_control_e)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_result = {31'b0, src_a < src_b};
            4'b0111: alu_result = src_a << src_b[4:0];
            4'b1000: alu_result = src_a >> src_b[4:0];
            4'b1001: alu_result = $signed(src_a) >>> src_b[4:0];
            default: alu_result = 32'b0;
        endcase
    end

    // Branches compare the forwarded rs2, never the immediate
    always_comb begin
        case (funct3_e)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) < $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a < fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_src_e    = jump_e | (branch_e & taken);
    assign pc_target_e = jalr_e ? ((src_a + imm_ext_e) & ~32'd1) : (pc_e + imm_ext_e);

    // Multiply magnitudes unsigned and fix the sign at the end; 0x80000000 stays exact
    assign a_signed  = (mul_op_e == 2'b01) || (mul_op_e == 2'b10);
    assign b_signed  = (mul_op_e == 2'b01);
    assign a_mag     = (a_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag     = (b_signed && fwd_b[31]) ? (32'd0 - fwd_b) : fwd_b;
    assign neg_start = (a_signed & src_a[31]) ^ (b_signed & fwd_b[31]);

    always_comb begin
        partial = 64'b0;
        for (int j = 0; j < K; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    assign product    = negate ? (64'd0 - acc) : acc;
    assign mul_result = (op == 2'b00) ? product[31:0] : product[63:32];
    assign mul_busy_e = ((state == IDLE) && mul_e) || (state == BUSY);

    always_ff @(posedge clk) begin
        if (srst) begin
            state  <= IDLE;
            count  <= 6'd0;
            acc    <= 64'b0;
            mcand  <= 64'b0;
            mplier <= 32'b0;
            op     <= 2'b00;
            negate <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_e) begin
                        acc    <= 64'b0;
                        mcand  <= {32'b0, a_mag};
                        mplier <= b_mag;
                        op     <= mul_op_e;
                        negate <= neg_start;
                        count  <= 6'd0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << K;
                    mplier <= mplier >> K;
                    count  <= count + 6'd1;
                    if (count == 6'(N - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled multiply presents bubbles to the memory stage
    always_ff @(posedge clk) begin
        if (srst || mul_busy_e) begin
            rd_m         <= 5'b0;
            alu_result_m <= 32'b0;
            write_data_m <= 32'b0;
            pc_plus4_m   <= 32'b0;
            result_src_m <= 2'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
        end else begin
            rd_m         <= rd_e;
            alu_result_m <= (state == DONE) ? mul_result : alu_result;
            write_data_m <= fwd_b;
            pc_plus4_m   <= pc_plus4_e;
            result_src_m <= result_src_e;
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: one instance per multiplier width,
// sharing all inputs except mul_e.
module tb_execute_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic [4:0]  rd_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
    logic        reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e, mul_op_e, forward_a_e, forward_b_e;
    logic [2:0]  funct3_e;
    logic [3:0]  alu_control_e;
    logic        mul_e1, mul_e4;

    logic [4:0]  o1_rd_m, o4_rd_m;
    logic [31:0] o1_alu_result_m, o4_alu_result_m, o1_write_data_m, o4_write_data_m;
    logic [31:0] o1_pc_plus4_m, o4_pc_plus4_m, o1_pc_target_e, o4_pc_target_e;
    logic        o1_reg_write_m, o4_reg_write_m, o1_mem_write_m, o4_mem_write_m;
    logic [1:0]  o1_result_src_m, o4_result_src_m;
    logic        o1_pc_src_e, o4_pc_src_e, o1_mul_busy_e, o4_mul_busy_e;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    execute_stage #(.MUL_BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .srst(srst), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .branch_e(branch_e), .funct3_e(funct3_e),
        .alu_src_e(alu_src_e), .alu_control_e(alu_control_e), .mul_e(mul_e1),
        .mul_op_e(mul_op_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .result_w(result_w), .rd_m(o1_rd_m), .alu_result_m(o1_alu_result_m),
        .write_data_m(o1_write_data_m), .pc_plus4_m(o1_pc_plus4_m),
        .reg_write_m(o1_reg_write_m), .result_src_m(o1_result_src_m),
        .mem_write_m(o1_mem_write_m), .pc_src_e(o1_pc_src_e),
        .pc_target_e(o1_pc_target_e), .mul_busy_e(o1_mul_busy_e)
    );

    execute_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .srst(srst), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .branch_e(branch_e), .funct3_e(funct3_e),
        .alu_src_e(alu_src_e), .alu_control_e(alu_control_e), .mul_e(mul_e4),
        .mul_op_e(mul_op_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .result_w(result_w), .rd_m(o4_rd_m), .alu_result_m(o4_alu_result_m),
        .write_data_m(o4_write_data_m), .pc_plus4_m(o4_pc_plus4_m),
        .reg_write_m(o4_reg_write_m), .result_src_m(o4_result_src_m),
        .mem_write_m(o4_mem_write_m), .pc_src_e(o4_pc_src_e),
        .pc_target_e(o4_pc_target_e), .mul_busy_e(o4_mul_busy_e)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mul_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = sa * sb;
            2'b10: p = sa * ub;
            default: p = {32'b0, a} * ub;
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic init_inputs();
        srst = 1'b0; rd_e = 5'd0; rd1_e = 32'd0; rd2_e = 32'd0; imm_ext_e = 32'd0;
        pc_e = 32'd0; pc_plus4_e = 32'd0; result_w = 32'd0; reg_write_e = 1'b0;
        mem_write_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0; branch_e = 1'b0;
        alu_src_e = 1'b0; result_src_e = 2'b0; mul_op_e = 2'b0; forward_a_e = 2'b0;
        forward_b_e = 2'b0; funct3_e = 3'b0; alu_control_e = 4'b0;
        mul_e1 = 1'b0; mul_e4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [135:0] all1, all4;
        init_inputs();
        srst = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b1; rd_e = 5'd7;
        rd1_e = 32'd5; pc_plus4_e = 32'd4; result_src_e = 2'b10;
        @(posedge clk); #1;
        all1 = {o1_rd_m, o1_alu_result_m, o1_write_data_m, o1_pc_plus4_m, o1_reg_write_m, o1_result_src_m, o1_mem_write_m};
        all4 = {o4_rd_m, o4_alu_result_m, o4_write_data_m, o4_pc_plus4_m, o4_reg_write_m, o4_result_src_m, o4_mem_write_m};
        tests_run++;
        if (all1 !== '0) begin tests_failed++; $display("[TB] FAIL reset_outputs_dut1 got %h expected 0", all1); end
        tests_run++;
        if (all4 !== '0) begin tests_failed++; $display("[TB] FAIL reset_outputs_dut4 got %h expected 0", all4); end
        tests_run++;
        if ({o1_mul_busy_e, o4_mul_busy_e} !== 2'b00) begin
            tests_failed++; $display("[TB] FAIL reset_busy got %b expected 00", {o1_mul_busy_e, o4_mul_busy_e});
        end
        init_inputs();
    endtask

    task automatic test_alu_forward();
        logic [31:0] a, b, fb, sb, exp_wd, got;
        logic [3:0]  c;
        init_inputs();
        reg_write_e = 1'b1; rd_e = 5'd3; rd1_e = 32'h10;
        exp_q.push_back(32'h10);
        @(posedge clk); #1;
        got = exp_q.pop_front();
        tests_run++;
        if (o1_alu_result_m !== got || o1_rd_m !== 5'd3 || o1_reg_write_m !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL alu_seed got %h/%0d/%b expected %h/3/1", o1_alu_result_m, o1_rd_m, o1_reg_write_m, got);
        end
        alu_control_e = 4'b0001; forward_a_e = 2'b10; rd1_e = 32'h999; rd2_e = 32'h3;
        exp_q.push_back(32'h0000000D);
        @(posedge clk); #1;
        got = exp_q.pop_front();
        tests_run++;
        if (o1_alu_result_m !== got || o1_write_data_m !== 32'h3) begin
            tests_failed++; $display("[TB] FAIL alu_fwd_sub got %h/%h expected %h/00000003", o1_alu_result_m, o1_write_data_m, got);
        end
        for (int i = 0; i < 32; i++) begin
            c = 4'(i % 16);
            a = $urandom; b = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            rd1_e = a; rd2_e = b; result_w = $urandom; imm_ext_e = $urandom;
            forward_a_e = (i % 2 == 0) ? 2'b00 : 2'b11;
            forward_b_e = (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b11 : 2'b00);
            alu_src_e = (i % 4 == 3);
            alu_control_e = c;
            fb = (forward_b_e == 2'b01) ? result_w : rd2_e;
            sb = alu_src_e ? imm_ext_e : fb;
            exp_q.push_back(alu_model(c, a, sb));
            exp_wd = fb;
            @(posedge clk); #1;
            got = exp_q.pop_front();
            tests_run++;
            if (o1_alu_result_m !== got || o4_alu_result_m !== got || o1_write_data_m !== exp_wd) begin
                tests_failed++;
                $display("[TB] FAIL alu_op%0d got %h/%h wd %h expected %h wd %h", c, o1_alu_result_m, o4_alu_result_m, o1_write_data_m, got, exp_wd);
            end
        end
        init_inputs();
    endtask

    task automatic test_branch();
        logic [2:0]  f3 [9] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
        logic [31:0] ra [9] = '{32'd5, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5};
        logic [31:0] rb [9] = '{32'd5, 32'd6, 32'd6, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd6};
        logic        ex [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        init_inputs();
        branch_e = 1'b1; pc_e = 32'h100; imm_ext_e = 32'h20; alu_src_e = 1'b1;
        for (int i = 0; i < 9; i++) begin
            funct3_e = f3[i]; rd1_e = ra[i]; rd2_e = rb[i];
            #1;
            tests_run++;
            if (o1_pc_src_e !== ex[i] || o1_pc_target_e !== 32'h120) begin
                tests_failed++;
                $display("[TB] FAIL branch_case%0d got src %b tgt %h expected src %b tgt 00000120", i, o1_pc_src_e, o1_pc_target_e, ex[i]);
            end
        end
        branch_e = 1'b0; funct3_e = 3'b000; rd1_e = 32'd5; rd2_e = 32'd5;
        #1;
        tests_run++;
        if (o1_pc_src_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL branch_disabled got %b expected 0", o1_pc_src_e); end
        init_inputs();
    endtask

    task automatic test_jalr();
        init_inputs();
        jump_e = 1'b1; jalr_e = 1'b1; rd1_e = 32'h1003; imm_ext_e = 32'h4;
        pc_e = 32'h500; pc_plus4_e = 32'h504; reg_write_e = 1'b1;
        #1;
        tests_run++;
        if (o1_pc_target_e !== 32'h1006 || o1_pc_src_e !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL jalr_target got %h/%b expected 00001006/1", o1_pc_target_e, o1_pc_src_e);
        end
        jalr_e = 1'b0;
        #1;
        tests_run++;
        if (o1_pc_target_e !== 32'h504 || o1_pc_src_e !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL jal_target got %h/%b expected 00000504/1", o1_pc_target_e, o1_pc_src_e);
        end
        @(posedge clk); #1;
        tests_run++;
        if (o1_pc_plus4_m !== 32'h504) begin tests_failed++; $display("[TB] FAIL jal_link got %h expected 00000504", o1_pc_plus4_m); end
        init_inputs();
    endtask

    task automatic test_mul(input int which, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit perturb);
        int n, busy_cnt, bubble_cnt, cycles;
        logic bsy, rw;
        logic [31:0] got_r, want;
        init_inputs();
        n = (which == 1) ? 32 : 8;
        rd1_e = a; rd2_e = b; result_w = a; forward_a_e = perturb ? 2'b01 : 2'b00;
        reg_write_e = 1'b1; rd_e = 5'd9; mul_op_e = o;
        if (which == 1) mul_e1 = 1'b1; else mul_e4 = 1'b1;
        exp_q.push_back(mul_model(o, a, b));
        busy_cnt = 0; bubble_cnt = 0; cycles = 0;
        while (cycles < 200) begin
            #1;
            bsy = (which == 1) ? o1_mul_busy_e : o4_mul_busy_e;
            if (bsy !== 1'b1) break;
            busy_cnt++;
            @(posedge clk); #1;
            if (perturb) result_w = $urandom;
            rw = (which == 1) ? o1_reg_write_m : o4_reg_write_m;
            if (rw === 1'b0) bubble_cnt++;
            cycles++;
        end
        tests_run++;
        if (cycles >= 200) begin
            tests_failed++; $display("[TB] FAIL mul_timeout op%0d dut%0d busy never dropped", o, which);
            void'(exp_q.pop_front());
            mul_e1 = 1'b0; mul_e4 = 1'b0;
            return;
        end
        if (busy_cnt != n + 1 || bubble_cnt != n + 1) begin
            tests_failed++;
            $display("[TB] FAIL mul_stall op%0d dut%0d got busy %0d bubbles %0d expected %0d", o, which, busy_cnt, bubble_cnt, n + 1);
        end
        @(posedge clk); #1;
        mul_e1 = 1'b0; mul_e4 = 1'b0;
        got_r = (which == 1) ? o1_alu_result_m : o4_alu_result_m;
        rw = (which == 1) ? o1_reg_write_m : o4_reg_write_m;
        want = exp_q.pop_front();
        tests_run++;
        if (got_r !== want || rw !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mul_result op%0d dut%0d a=%h b=%h got %h rw %b expected %h rw 1", o, which, a, b, got_r, rw, want);
        end
        init_inputs();
    endtask

    task automatic test_mul_reset();
        logic [135:0] all1;
        init_inputs();
        rd1_e = 32'd3; rd2_e = 32'd4; reg_write_e = 1'b1; mul_e1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        srst = 1'b1; mul_e1 = 1'b0;
        @(posedge clk); #1;
        srst = 1'b0;
        all1 = {o1_rd_m, o1_alu_result_m, o1_write_data_m, o1_pc_plus4_m, o1_reg_write_m, o1_result_src_m, o1_mem_write_m};
        tests_run++;
        if (o1_mul_busy_e !== 1'b0 || all1 !== '0) begin
            tests_failed++; $display("[TB] FAIL mul_abort got busy %b outputs %h expected 0/0", o1_mul_busy_e, all1);
        end
        init_inputs();
    endtask

    task automatic test_back_to_back();
        test_mul(1, 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        test_mul(4, 2'b01, 32'hFFFFFFF9, 32'h00000003, 1'b0);
        test_mul(4, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        init_inputs();
        @(posedge clk); #1;
        test_reset();
        test_alu_forward();
        test_branch();
        test_jalr();
        test_mul(1, 2'b00, 32'd7, 32'hFFFFFFFD, 1'b0);
        test_mul(1, 2'b01, 32'h80000000, 32'h80000000, 1'b0);
        test_mul(1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mul(1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mul(4, 2'b00, 32'd7, 32'hFFFFFFFD, 1'b0);
        test_mul(4, 2'b01, 32'h80000000, 32'h80000000, 1'b0);
        test_mul(4, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mul(4, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mul(1, 2'b01, 32'hDEADBEEF, 32'h87654321, 1'b1);
        test_mul_reset();
        test_mul(1, 2'b11, 32'hCAFEF00D, 32'h0BADF00D, 1'b0);
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
